shift_operand_collector: RTL and testbench
==========================================

// Module: shift_operand_collector
// PURPOSE
// - Upstream feeder for the packed multi-lane shift unit (nBit_Shift lanes).
// - Accepts one lane per beat over valid/ready: operand plus decoded command (dir, amt, fill).
// - Encodes each command into the lane shift-control word and assembles SETS lanes into
//   registered packed words: in_packed and shift_packed.
// - Presents each complete or flushed bundle downstream over valid/ready.
// PARAMETERS
// - WIDTH  default 4  lane bit width; must be >= 3 (amt field is WIDTH-2 bits)
// - SETS   default 2  lanes per bundle; must be >= 1
// PORTS
// - clk          input   1             clock, rising edge
// - rst          input   1             reset, asynchronous, active-high
// - in_valid     input   1             lane beat valid
// - in_ready     output  1             collector can accept a beat
// - in_data      input   WIDTH         lane operand
// - in_dir       input   1             0 = left, 1 = right
// - in_amt       input   WIDTH-2       shift amount
// - in_fill      input   1             fill bit
// - in_last      input   1             close bundle after this beat, even if lanes < SETS
// - out_valid    output  1             bundle valid
// - out_ready    input   1             downstream accepts bundle
// - in_packed    output  SETS*WIDTH    operands; lane i at [i*WIDTH +: WIDTH]
// - shift_packed output  SETS*WIDTH    control words; lane i at [i*WIDTH +: WIDTH]
// - lane_mask    output  SETS          bit i = lane i carries a real beat
// BEHAVIOUR
// - Control word: word[0] = dir; word[WIDTH-2:1] = amt; word[WIDTH-1] = fill.
// - Reset (async, takes effect immediately, including mid-bundle):
//   - state = COLLECT, lane index = 0.
//   - in_packed, shift_packed, lane_mask = 0; out_valid = 0; in_ready = 1 once rst falls.
//   - A partial bundle is discarded.
// - The first accepted beat of a bundle goes to lane 0; following beats take increasing lanes.
// - A beat is accepted when in_valid && in_ready at the rising edge. It writes the lane
//   operand, the control word and lane_mask[idx] = 1.
// - FSM COLLECT:
//   - in_ready = 1, out_valid = 0.
//   - On accept with idx == SETS-1 or in_last = 1: go to PRESENT next cycle, idx -> 0.
//   - Otherwise idx increments.
// - FSM PRESENT:
//   - out_valid = 1; outputs hold stable until out_ready.
//   - in_ready = out_ready (combinational pass-through).
//   - out_ready = 1 with no new beat: go to COLLECT; clear all lanes and lane_mask.
//   - out_ready = 1 with a new beat: clear all lanes, write the beat to lane 0, and set
//     lane_mask = 1 in the same edge.
//     - If that beat also closes the bundle (SETS == 1 or in_last), stay in PRESENT.
//     - Otherwise go to COLLECT with idx = 1.
// - Unused lanes of a flushed bundle read operand 0 and control 0 (left shift by 0).
// - Latency: a bundle is visible the cycle after its closing beat. Peak throughput is
//   SETS beats per SETS cycles, with no bubble when out_ready is held at 1.
// - in_valid with in_ready = 0 is ignored; the sender holds the beat.
// - Arithmetic: fields are copied, never truncated. amt is exactly WIDTH-2 bits and
//   lane idx is clog2(SETS) bits, with idx < SETS always.
// STRUCTURE
// - Shared package/header (shift_pkg):
//   - Control-word field positions: DIR_BIT = 0, AMT_LSB = 1, FILL_BIT = WIDTH-1.
//   - FSM state encodings: COLLECT = 1'b0, PRESENT = 1'b1.
//   - A function that builds the control word from dir, amt and fill.
// - One natural sub-module, shift_ctrl_encode: combinational dir/amt/fill -> WIDTH-bit word.
//   The same encoder is reused by any other producer of shift commands.
// - The top level holds the FSM, lane index counter, lane registers and handshake.
// TESTING (WIDTH=4, SETS=2)
// - Full bundle:
//   - Stimulus: beat 0110/dir0/amt1/fill0, then 1001/dir1/amt2/fill1.
//   - Response: next cycle out_valid = 1, in_packed = 8'h96, shift_packed = 8'hD2,
//     lane_mask = 2'b11.
// - Flush:
//   - Stimulus: single beat 1111/dir1/amt3/fill0 with in_last = 1.
//   - Response: in_packed = 8'h0F, shift_packed = 8'h07, lane_mask = 2'b01.
// - Backpressure:
//   - Stimulus: hold out_ready = 0 for 5 cycles after a bundle.
//   - Response: outputs stable, in_ready = 0, further beats not taken. Release ->
//     one handshake, then state COLLECT.
// - Drain plus accept:
//   - Stimulus: out_ready = 1 and new beat 0011/dir0/amt0/fill1 in PRESENT.
//   - Response: old bundle consumed; next cycle lane 0 = 0011, control = 4'h8,
//     lane_mask = 2'b01, out_valid = 0.
// - Reset mid-bundle:
//   - Stimulus: assert rst asynchronously after lane 0 is filled.
//   - Response: all outputs 0 immediately, out_valid = 0. After release, the next beat
//     lands in lane 0.
// - Streaming: 8 back-to-back beats with out_ready = 1 -> 4 bundles, no stall cycle,
//   lane order preserved.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for shift-command producers: control-word layout,
// collector FSM states and the control-word builder.
package shift_pkg;

  // Control-word field positions; the fill bit always sits in the MSB.
  localparam int DIR_BIT   = 0;
  localparam int AMT_LSB   = 1;
  // Widest lane the builder supports.
  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Position of the fill bit for a given lane width.
  function automatic int fill_bit(input int width);
    return width - 1;
  endfunction

  // Build a control word of 'width' bits:
  //   {fill, amt[width-3:0], dir}
  // Callers take the low 'width' bits. Amount bits above the field are masked off.
  function automatic logic [MAX_WIDTH-1:0] build_ctrl(
    input int                   width,
    input logic                 dir,
    input logic [MAX_WIDTH-1:0] amt,
    input logic                 fill
  );
    logic [MAX_WIDTH-1:0] amt_mask;
    logic [MAX_WIDTH-1:0] word;
    amt_mask = (MAX_WIDTH'(1) << (width - 2)) - MAX_WIDTH'(1);
    word = '0;
    word[DIR_BIT] = dir;
    word = word | ((amt & amt_mask) << AMT_LSB);
    word[fill_bit(width)] = fill;
    return word;
  endfunction

endpackage

// File: rtl/shift_ctrl_encode.sv
// Combinational encoder: decoded shift command (dir, amt, fill) to the
// WIDTH-bit lane control word used by the packed shift unit.
module shift_ctrl_encode
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             dir,
  input  logic [WIDTH-3:0] amt,
  input  logic             fill,
  output logic [WIDTH-1:0] ctrl
);

  assign ctrl = WIDTH'(build_ctrl(WIDTH, dir, MAX_WIDTH'(amt), fill));

endmodule

// File: rtl/shift_operand_collector.sv
// Collects one lane per beat (operand + shift command) into packed bundles of
// SETS lanes and presents each complete or flushed bundle over valid/ready.
module shift_operand_collector
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_dir,
  input  logic [WIDTH-3:0]      in_amt,
  input  logic                  in_fill,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SETS*WIDTH-1:0] in_packed,
  output logic [SETS*WIDTH-1:0] shift_packed,
  output logic [SETS-1:0]       lane_mask
);

  localparam int              IDX_W    = (SETS > 1) ? $clog2(SETS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [SETS*WIDTH-1:0] in_packed_d, shift_packed_d;
  logic [SETS-1:0]       lane_mask_d;
  logic [WIDTH-1:0]      ctrl_word;
  logic                  accept;
  logic                  closing;
  logic                  clear;

  shift_ctrl_encode #(.WIDTH(WIDTH)) u_encode (
    .dir  (in_dir),
    .amt  (in_amt),
    .fill (in_fill),
    .ctrl (ctrl_word)
  );

  // In PRESENT, a beat can only enter when the held bundle leaves on the same edge.
  assign in_ready  = !rst && ((state == COLLECT) || out_ready);
  assign out_valid = (state == PRESENT);
  assign accept    = in_valid && in_ready;
  // idx is 0 in PRESENT, so this also covers the SETS == 1 case there.
  assign closing   = (idx == LAST_IDX) || in_last;

  // Next state, next lane index and bundle-clear decision.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    idx_d   = idx;
    clear   = 1'b0;
    unique case (state)
      COLLECT: begin
        if (accept) begin
          if (closing) begin
            state_d = PRESENT;
            idx_d   = '0;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          clear = 1'b1;
          if (accept && closing) begin
            state_d = PRESENT;
            idx_d   = '0;
          end else if (accept) begin
            state_d = COLLECT;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = COLLECT;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  // Next lane contents: clear on handshake, then write the accepted beat into lane idx.
  always_comb begin
    in_packed_d    = in_packed;
    shift_packed_d = shift_packed;
    lane_mask_d    = lane_mask;
    if (clear) begin
      in_packed_d    = '0;
      shift_packed_d = '0;
      lane_mask_d    = '0;
    end
    if (accept) begin
      in_packed_d[idx*WIDTH +: WIDTH]    = in_data;
      shift_packed_d[idx*WIDTH +: WIDTH] = ctrl_word;
      lane_mask_d[idx]                   = 1'b1;
    end
  end

  // FSM state and lane index registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= COLLECT;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Lane registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the lane storage is reset too, because unused lanes of a flushed bundle must read 0.
    if (rst) begin
      in_packed    <= '0;
      shift_packed <= '0;
      lane_mask    <= '0;
    end else begin
      in_packed    <= in_packed_d;
      shift_packed <= shift_packed_d;
      lane_mask    <= lane_mask_d;
    end
  end

endmodule

// File: tb/tb_shift_operand_collector.sv
// Self-checking bench for shift_operand_collector (WIDTH=4, SETS=2): a bench-side
// bundle model pushes expected bundles to a queue; each downstream handshake pops one.
module tb_shift_operand_collector;

  localparam int WIDTH = 4;
  localparam int SETS  = 2;

  typedef struct packed {
    logic [SETS*WIDTH-1:0] data;
    logic [SETS*WIDTH-1:0] ctrl;
    logic [SETS-1:0]       mask;
  } bundle_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  in_dir;
  logic [WIDTH-3:0]      in_amt;
  logic                  in_fill;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [SETS*WIDTH-1:0] in_packed;
  logic [SETS*WIDTH-1:0] shift_packed;
  logic [SETS-1:0]       lane_mask;

  bundle_t sb_q[$];
  bundle_t cur;
  int      cur_idx;
  int      n_tests;
  int      n_fail;
  int      n_handshakes;
  logic    acc;

  shift_operand_collector #(.WIDTH(WIDTH), .SETS(SETS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_dir       (in_dir),
    .in_amt       (in_amt),
    .in_fill      (in_fill),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .in_packed    (in_packed),
    .shift_packed (shift_packed),
    .lane_mask    (lane_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock: drive at negedge, evaluate handshakes just after, DUT samples on the next posedge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic dr,
                       input logic [WIDTH-3:0] a, input logic f, input logic l,
                       input logic ordy, output logic accepted);
    bundle_t exp;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_dir    = dr;
    in_amt    = a;
    in_fill   = f;
    in_last   = l;
    out_ready = ordy;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_handshakes++;
      if (sb_q.size() == 0) begin
        check("unexpected_bundle", {31'b0, out_valid}, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check("bundle_data", 32'(in_packed), 32'(exp.data));
        check("bundle_ctrl", 32'(shift_packed), 32'(exp.ctrl));
        check("bundle_mask", 32'(lane_mask), 32'(exp.mask));
      end
    end
    if (accepted) begin
      cur.data[cur_idx*WIDTH +: WIDTH] = d;
      cur.ctrl[cur_idx*WIDTH +: WIDTH] = {f, a, dr};
      cur.mask[cur_idx]                = 1'b1;
      if (cur_idx == SETS - 1 || l) begin
        sb_q.push_back(cur);
        cur     = '0;
        cur_idx = 0;
      end else begin
        cur_idx++;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    logic a_unused;
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, ordy, a_unused);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) idle(1'b1);
    check("drain_done", sb_q.size(), 32'd0);
  endtask

  initial begin
    int stalls;
    int hs_start;
    n_tests = 0; n_fail = 0; n_handshakes = 0;
    cur = '0; cur_idx = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_amt = '0;
    in_fill = 1'b0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_packed", 32'(in_packed), 32'd0);
    check("rst_shift_packed", 32'(shift_packed), 32'd0);
    check("rst_lane_mask", 32'(lane_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Full bundle, then backpressure for 5 cycles
    cycle(1'b1, 4'b0110, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 4'b1001, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, acc);
    idle(1'b0);
    check("full_valid", {31'b0, out_valid}, 32'd1);
    check("full_in_packed", 32'(in_packed), 32'h96);
    check("full_shift_packed", 32'(shift_packed), 32'hD2);
    check("full_mask", 32'(lane_mask), 32'h3);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b0101, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, acc);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_not_taken", {31'b0, acc}, 32'd0);
      check("bp_hold_data", 32'(in_packed), 32'h96);
      check("bp_hold_ctrl", 32'(shift_packed), 32'hD2);
    end
    hs_start = n_handshakes;
    idle(1'b1);
    idle(1'b0);
    check("bp_one_handshake", n_handshakes - hs_start, 32'd1);
    check("bp_back_collect", {31'b0, out_valid}, 32'd0);
    check("bp_ready_collect", {31'b0, in_ready}, 32'd1);
    check("bp_cleared_mask", 32'(lane_mask), 32'd0);

    // Flush with in_last
    cycle(1'b1, 4'b1111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, acc);
    idle(1'b0);
    check("flush_valid", {31'b0, out_valid}, 32'd1);
    check("flush_in_packed", 32'(in_packed), 32'h0F);
    check("flush_shift_packed", 32'(shift_packed), 32'h07);
    check("flush_mask", 32'(lane_mask), 32'h1);

    // Drain plus accept in PRESENT
    cycle(1'b1, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, acc);
    check("dpa_accepted", {31'b0, acc}, 32'd1);
    idle(1'b0);
    check("dpa_out_valid", {31'b0, out_valid}, 32'd0);
    check("dpa_in_packed", 32'(in_packed), 32'h03);
    check("dpa_shift_packed", 32'(shift_packed), 32'h08);
    check("dpa_mask", 32'(lane_mask), 32'h1);
    cycle(1'b1, 4'b1010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Reset mid-bundle
    cycle(1'b1, 4'b0101, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mid_lane0_filled", 32'(lane_mask), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_packed", 32'(in_packed), 32'd0);
    check("mid_rst_shift_packed", 32'(shift_packed), 32'd0);
    check("mid_rst_mask", 32'(lane_mask), 32'd0);
    cur = '0; cur_idx = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 4'b1100, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, acc);
    drain();

    // Streaming: 8 back-to-back beats with out_ready held high
    stalls = 0;
    hs_start = n_handshakes;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b1, acc);
      if (!acc) stalls++;
    end
    drain();
    check("stream_stalls", stalls, 32'd0);
    check("stream_bundles", n_handshakes - hs_start, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
